// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_req_arbiter
// Brief    : Round-robin arbiter sharing one APB slave port between NUM_REQ
//            local requesters, with SETUP/ACCESS sequencing, per-requester
//            response routing and an optional ACCESS-phase timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                           pclk,
  input  logic                           prst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ*4-1:0]           req_strb,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic                           psel,
  output logic                           penable,
  output logic [ADDR_WIDTH-1:0]          paddr,
  output logic                           pwrite,
  output logic [DATA_WIDTH-1:0]          pwdata,
  output logic [3:0]                     pstrb,
  input  logic [DATA_WIDTH-1:0]          prdata,
  input  logic                           pready,
  input  logic                           pslverr
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Wait counter is sized for TIMEOUT; a disabled timeout still needs one bit.
  localparam int WCW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [IDXW-1:0]    C_LAST_RST   = IDXW'(NUM_REQ - 1);
  localparam logic [WCW-1:0]     C_WAIT_LIMIT = (TIMEOUT > 0) ? WCW'(TIMEOUT - 1) : '0;
  localparam logic [WCW-1:0]     C_WAIT_MAX   = (TIMEOUT > 0) ? WCW'(TIMEOUT) : '1;
  localparam logic [NUM_REQ-1:0] C_ONE        = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                  state_q;
  logic [IDXW-1:0]         last_grant_q;
  logic [WCW-1:0]          wait_cnt_q;
  logic                    psel_q;
  logic                    penable_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [3:0]              pstrb_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;

  logic [IDXW-1:0]         win_idx_d;
  logic                    win_vld_d;
  logic [NUM_REQ-1:0]      grant_oh_d;

  // Unpacked views of the packed request payload buses
  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
  logic [3:0]              strb_arr  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign strb_arr[gi]  = req_strb[gi*4 +: 4];
    end
  endgenerate

  // Round-robin pick: first valid requester searching upward from last_grant+1
  always_comb begin
    int              cand;
    logic [IDXW-1:0] cand_idx;
    win_idx_d = '0;
    win_vld_d = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDXW'(cand);
      if (!win_vld_d && req_valid[cand_idx]) begin
        win_vld_d = 1'b1;
        win_idx_d = cand_idx;
      end
    end
  end

  // Accept pulse only in IDLE; forced low while reset is asserted
  assign grant_oh_d = (state_q == S_IDLE && win_vld_d) ? (C_ONE << win_idx_d) : '0;
  assign req_ready  = prst_n ? grant_oh_d : '0;

  // Transfer sequencer: arbitration, APB phases, completion and timeout
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= C_LAST_RST;
      wait_cnt_q   <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            paddr_q      <= addr_arr[win_idx_d];
            pwrite_q     <= req_write[win_idx_d];
            pwdata_q     <= wdata_arr[win_idx_d];
            // Reads never carry strobes
            pstrb_q      <= req_write[win_idx_d] ? strb_arr[win_idx_d] : 4'h0;
            last_grant_q <= win_idx_d;
            psel_q       <= 1'b1;
            state_q      <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= S_ACCESS;
        end
        S_ACCESS: begin
          // pready wins over a timeout landing in the same cycle
          if (pready) begin
            rsp_valid_q <= C_ONE << last_grant_q;
            rsp_rdata_q <= prdata;
            rsp_err_q   <= pslverr;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= S_IDLE;
          end else if ((TIMEOUT != 0) && (wait_cnt_q == C_WAIT_LIMIT)) begin
            rsp_valid_q <= C_ONE << last_grant_q;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= S_IDLE;
          end else if (wait_cnt_q != C_WAIT_MAX) begin
            wait_cnt_q <= wait_cnt_q + WCW'(1);
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire
